// File: rtl/word_byte_splitter.sv
// rtl/word_byte_splitter.sv - word-to-byte serializer with valid/ready on both sides
// Holds one word in a shift register and emits WORD_W/8 bytes with zero-bubble word handoff.
module word_byte_splitter #(
  parameter int WORD_W    = 16,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_word,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_byte,
  output logic              out_last
);

  localparam int NB    = WORD_W / 8;
  localparam int IDX_W = $clog2(NB);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [WORD_W-1:0] word_q, word_d;

  logic [7:0]        emit_byte;
  logic [WORD_W-1:0] word_shifted;
  logic              accept;
  logic              xfer;

  // The emit end of the register always holds the current byte, so shifting toward it advances.
  always_comb begin
    emit_byte    = MSB_FIRST ? word_q[WORD_W-1 -: 8] : word_q[7:0];
    word_shifted = MSB_FIRST ? {word_q[WORD_W-9:0], 8'h00} : {8'h00, word_q[WORD_W-1:8]};
  end

  always_comb begin
    out_valid = (state_q == SEND);
    out_byte  = out_valid ? emit_byte : 8'h00;
    out_last  = out_valid && (idx_q == LAST_IDX);
    in_ready  = (state_q == IDLE) || (out_ready && out_last);
    accept    = in_valid && in_ready;
    xfer      = out_valid && out_ready;
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    word_d  = word_q;
    if (xfer && !out_last) begin
      idx_d  = idx_q + IDX_W'(1);
      word_d = word_shifted;
    end else if (xfer && out_last) begin
      idx_d   = '0;
      word_d  = '0;
      state_d = IDLE;
    end
    // A load on the final transfer overrides the wrap to IDLE.
    if (accept) begin
      word_d  = in_word;
      idx_d   = '0;
      state_d = SEND;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
    end
  end

endmodule

// File: tb/tb_word_byte_splitter.sv
// tb/tb_word_byte_splitter.sv - self-checking bench for word_byte_splitter
// Directed scenarios plus randomized traffic against a byte-queue reference model.
module tb_word_byte_splitter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        a_in_valid = 1'b0, a_in_ready, a_out_valid, a_out_ready = 1'b0, a_out_last;
  logic [15:0] a_in_word = '0;
  logic [7:0]  a_out_byte;
  logic        b_in_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b0, b_out_last;
  logic [31:0] b_in_word = '0;
  logic [7:0]  b_out_byte;

  int errors = 0;
  int checks = 0;

  word_byte_splitter #(.WORD_W(16), .MSB_FIRST(1'b1)) dut_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_word(a_in_word),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_byte(a_out_byte), .out_last(a_out_last));

  word_byte_splitter #(.WORD_W(32), .MSB_FIRST(1'b0)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_word(b_in_word),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_byte(b_out_byte), .out_last(b_out_last));

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    next_cycle();
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({a_out_valid, a_out_byte, a_out_last, a_in_ready} !== {1'b0, 8'h00, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_a got v=%b b=%h l=%b r=%b exp v=0 b=00 l=0 r=1",
               a_out_valid, a_out_byte, a_out_last, a_in_ready);
    end
    checks++;
    if ({b_out_valid, b_out_byte, b_out_last, b_in_ready} !== {1'b0, 8'h00, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_b got v=%b b=%h l=%b r=%b exp v=0 b=00 l=0 r=1",
               b_out_valid, b_out_byte, b_out_last, b_in_ready);
    end
    next_cycle();
  endtask

  task automatic test_single();
    a_out_ready = 1'b1;
    a_in_valid  = 1'b1;
    a_in_word   = 16'hA55A;
    next_cycle();
    a_in_valid = 1'b0;
    a_in_word  = 16'hFFFF;
    @(negedge clk);
    checks++;
    if ({a_out_valid, a_out_byte, a_out_last, a_in_ready} !== {1'b1, 8'hA5, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL single_b0 got v=%b b=%h l=%b r=%b exp v=1 b=a5 l=0 r=0",
               a_out_valid, a_out_byte, a_out_last, a_in_ready);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if ({a_out_valid, a_out_byte, a_out_last, a_in_ready} !== {1'b1, 8'h5A, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL single_b1 got v=%b b=%h l=%b r=%b exp v=1 b=5a l=1 r=1",
               a_out_valid, a_out_byte, a_out_last, a_in_ready);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if ({a_out_valid, a_out_byte, a_out_last, a_in_ready} !== {1'b0, 8'h00, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL single_idle got v=%b b=%h l=%b r=%b exp v=0 b=00 l=0 r=1",
               a_out_valid, a_out_byte, a_out_last, a_in_ready);
    end
    next_cycle();
  endtask

  task automatic test_back_to_back();
    logic [15:0] words [3] = '{16'h1234, 16'hABCD, 16'h00FF};
    logic [7:0]  exp_b [6] = '{8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'hFF};
    int wi = 0;
    a_out_ready = 1'b1;
    a_in_valid  = 1'b1;
    a_in_word   = words[0];
    for (int cyc = 0; cyc < 8; cyc++) begin
      @(negedge clk);
      if (cyc >= 1 && cyc <= 6) begin
        checks++;
        if ({a_out_valid, a_out_byte, a_out_last, a_in_ready} !==
            {1'b1, exp_b[cyc-1], (cyc % 2 == 0), (cyc % 2 == 0)}) begin
          errors++;
          $display("FAIL b2b_cyc%0d got v=%b b=%h l=%b r=%b exp v=1 b=%h l=%b r=%b", cyc,
                   a_out_valid, a_out_byte, a_out_last, a_in_ready,
                   exp_b[cyc-1], (cyc % 2 == 0), (cyc % 2 == 0));
        end
      end else if (cyc == 7) begin
        checks++;
        if (a_out_valid !== 1'b0) begin
          errors++;
          $display("FAIL b2b_end out_valid got=%b exp=0", a_out_valid);
        end
      end
      if (a_in_valid && a_in_ready) wi++;
      next_cycle();
      a_in_valid = (wi < 3);
      a_in_word  = (wi < 3) ? words[wi] : 16'h0000;
    end
  endtask

  task automatic test_backpressure();
    a_out_ready = 1'b0;
    a_in_valid  = 1'b1;
    a_in_word   = 16'hBEEF;
    next_cycle();
    a_in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      a_out_ready = (k == 3);
      @(negedge clk);
      checks++;
      if ({a_out_valid, a_out_byte, a_out_last, a_in_ready} !== {1'b1, 8'hBE, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL bp_hold%0d got v=%b b=%h l=%b r=%b exp v=1 b=be l=0 r=0", k,
                 a_out_valid, a_out_byte, a_out_last, a_in_ready);
      end
      next_cycle();
    end
    @(negedge clk);
    checks++;
    if ({a_out_valid, a_out_byte, a_out_last, a_in_ready} !== {1'b1, 8'hEF, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL bp_last got v=%b b=%h l=%b r=%b exp v=1 b=ef l=1 r=1",
               a_out_valid, a_out_byte, a_out_last, a_in_ready);
    end
    next_cycle();
  endtask

  task automatic test_reset_mid_word();
    a_out_ready = 1'b1;
    a_in_valid  = 1'b1;
    a_in_word   = 16'hC0DE;
    next_cycle();
    a_in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({a_out_valid, a_out_byte} !== {1'b1, 8'hC0}) begin
      errors++;
      $display("FAIL rstmid_b0 got v=%b b=%h exp v=1 b=c0", a_out_valid, a_out_byte);
    end
    next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if ({a_out_valid, a_out_byte, a_out_last, a_in_ready} !== {1'b0, 8'h00, 1'b0, 1'b1}) begin
        errors++;
        $display("FAIL rstmid_idle%0d got v=%b b=%h l=%b r=%b exp v=0 b=00 l=0 r=1", k,
                 a_out_valid, a_out_byte, a_out_last, a_in_ready);
      end
      next_cycle();
    end
  endtask

  task automatic test_lsb_wide();
    logic [7:0] exp_b [4] = '{8'h44, 8'h33, 8'h22, 8'h11};
    b_out_ready = 1'b1;
    b_in_valid  = 1'b1;
    b_in_word   = 32'h11223344;
    next_cycle();
    b_in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if ({b_out_valid, b_out_byte, b_out_last} !== {1'b1, exp_b[k], (k == 3)}) begin
        errors++;
        $display("FAIL lsb_b%0d got v=%b b=%h l=%b exp v=1 b=%h l=%b", k,
                 b_out_valid, b_out_byte, b_out_last, exp_b[k], (k == 3));
      end
      next_cycle();
    end
    @(negedge clk);
    checks++;
    if (b_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL lsb_end out_valid got=%b exp=0", b_out_valid);
    end
    next_cycle();
  endtask

  task automatic test_held_off();
    logic [7:0] exp_b [8] = '{8'hDD, 8'hCC, 8'hBB, 8'hAA, 8'h04, 8'h03, 8'h02, 8'h01};
    b_out_ready = 1'b1;
    b_in_valid  = 1'b1;
    b_in_word   = 32'hAABBCCDD;
    next_cycle();
    b_in_word = 32'h01020304;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checks++;
      if ({b_out_valid, b_out_byte, b_out_last} !== {1'b1, exp_b[k], (k % 4 == 3)}) begin
        errors++;
        $display("FAIL held_b%0d got v=%b b=%h l=%b exp v=1 b=%h l=%b", k,
                 b_out_valid, b_out_byte, b_out_last, exp_b[k], (k % 4 == 3));
      end
      if (k < 4) begin
        checks++;
        if (b_in_ready !== (k == 3)) begin
          errors++;
          $display("FAIL held_ready%0d got=%b exp=%b", k, b_in_ready, (k == 3));
        end
      end
      next_cycle();
      if (k == 3) b_in_valid = 1'b0;
    end
  endtask

  // Reference: a queue of the bytes still owed, in emit order; only its size and head matter.
  task automatic test_random(input bit sel, input int cycles);
    logic [7:0]  q[$];
    logic [31:0] w;
    logic        iv, ordy, ov, ol, ir, exp_ir;
    logic [7:0]  ob;
    int          nb;
    nb = sel ? 4 : 2;
    q.delete();
    for (int c = 0; c < cycles; c++) begin
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 2) != 0);
      w    = $urandom();
      if (!sel) w[31:16] = 16'h0000;
      if (sel) begin
        b_in_valid = iv; b_out_ready = ordy; b_in_word = w;
      end else begin
        a_in_valid = iv; a_out_ready = ordy; a_in_word = w[15:0];
      end
      @(negedge clk);
      ov = sel ? b_out_valid : a_out_valid;
      ob = sel ? b_out_byte  : a_out_byte;
      ol = sel ? b_out_last  : a_out_last;
      ir = sel ? b_in_ready  : a_in_ready;
      exp_ir = (q.size() == 0) || (ordy && q.size() == 1);
      checks++;
      if (ir !== exp_ir) begin
        errors++;
        $display("FAIL rand%0d_c%0d in_ready got=%b exp=%b", sel, c, ir, exp_ir);
      end
      if (q.size() != 0) begin
        checks++;
        if ({ov, ob, ol} !== {1'b1, q[0], (q.size() == 1)}) begin
          errors++;
          $display("FAIL rand%0d_c%0d out got v=%b b=%h l=%b exp v=1 b=%h l=%b", sel, c,
                   ov, ob, ol, q[0], (q.size() == 1));
        end
        if (ordy) void'(q.pop_front());
      end else begin
        checks++;
        if ({ov, ob, ol} !== {1'b0, 8'h00, 1'b0}) begin
          errors++;
          $display("FAIL rand%0d_c%0d idle got v=%b b=%h l=%b exp v=0 b=00 l=0", sel, c, ov, ob, ol);
        end
      end
      if (iv && exp_ir) begin
        for (int k = 0; k < nb; k++) begin
          if (sel) q.push_back(8'((w >> (8 * k)) & 32'hFF));
          else     q.push_back(8'((w >> (8 * (nb - 1 - k))) & 32'hFF));
        end
      end
      next_cycle();
    end
    if (sel) b_in_valid = 1'b0; else a_in_valid = 1'b0;
  endtask

  initial begin
    next_cycle();
    test_reset();
    test_single();
    test_back_to_back();
    a_in_valid = 1'b0;
    next_cycle();
    test_backpressure();
    test_reset_mid_word();
    test_lsb_wide();
    test_held_off();
    test_reset();
    test_random(1'b0, 400);
    test_reset();
    test_random(1'b1, 400);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/word_byte_splitter.md
# word_byte_splitter

Word-to-byte serializer. Accepts one WORD_W-bit word over a valid/ready handshake and emits it as WORD_W/8 consecutive bytes over a second valid/ready handshake. It is the transmit-side counterpart of the byte-concatenation path, which builds a word from `{getbyte(hi), getbyte(lo)}`. It sits between a word-wide producer and a byte-wide link or FIFO.

## Interface
Parameters:
- `WORD_W`, default 16: input word width. Must be a multiple of 8 and at least 16. NB = WORD_W/8 bytes per word.
- `MSB_FIRST`, default 1:
  - 1: emit bits [WORD_W-1:WORD_W-8] first.
  - 0: emit bits [7:0] first.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `in_valid` in 1: producer has a word on `in_word`.
- `in_ready` out 1: splitter accepts the word this cycle.
- `in_word` in WORD_W: word to serialize.
- `out_valid` out 1: `out_byte` holds a valid byte.
- `out_ready` in 1: consumer takes the byte this cycle.
- `out_byte` out 8: current byte.
- `out_last` out 1: current byte is the final byte of its word.

## Operation
- Input handshake: a word is accepted when `in_valid && in_ready` at a rising edge. An output byte is transferred when `out_valid && out_ready` at a rising edge.
- State machine:
  - IDLE: no word held.
  - SEND: word held in a WORD_W-bit shift register; byte index `idx` runs 0..NB-1.
- IDLE:
  - `in_ready`=1, `out_valid`=0.
  - On accept: load the register, set `idx`=0, go to SEND.
- SEND:
  - `out_valid`=1.
  - `out_byte` is byte `idx` in emit order.
  - `out_last` = (`idx`==NB-1).
- Transfer with `idx`<NB-1: `idx` increments; the register shifts by 8 toward the emit end.
- Transfer with `idx`==NB-1:
  - If `in_valid` is also high, load the new word, set `idx`=0, and stay in SEND. This is a zero-bubble handoff.
  - Otherwise, go to IDLE and set `idx`=0 (wrap).
- `in_ready` = IDLE, or (SEND && `out_ready` && `out_last`). It is combinational from `out_ready`. No other combinational path from inputs to outputs exists.
- Backpressure: while `out_valid && !out_ready`, `out_byte`, `out_last`, `idx` and the held word remain stable.
- `in_word` is sampled only on accept. Changes at other times are ignored.
- `in_valid` while SEND and not on the last transfer: `in_ready`=0 and the word is not taken. The producer must hold it.
- When `out_valid`=0, `out_byte` and `out_last` are 0.

## Timing
- Reset (`rst`=1 at an edge) sets: state IDLE, `idx`=0, held word 0, `out_valid`=0, `out_byte`=8'h00, `out_last`=0.
- After reset, `in_ready`=1 in the first cycle.
- Reset mid-word: any remaining bytes are discarded, with no partial `out_last`. `rst` overrides any simultaneous handshake.
- Latency: a word accepted at edge k has its first byte valid in the cycle after edge k.
- Throughput with `out_ready` held at 1: one byte per cycle. Back-to-back words take exactly NB cycles per word with no idle cycle.
- A word whose last byte transfers at edge m with no new word pending: `out_valid`=0 from edge m. A new word accepted at edge m+j appears at edge m+j+1.

## Test plan
- **Single word, no stall:** after reset, apply `in_word`=16'hA55A (MSB_FIRST=1) with `out_ready`=1.
  - Bytes A5 then 5A on consecutive cycles.
  - `out_last`=0 then 1.
  - `out_valid` drops the next cycle and `in_ready`=1.
- **Back-to-back words:** drive 16'h1234, 16'hABCD, 16'h00FF with `in_valid` and `out_ready` held at 1.
  - Stream is 12,34,AB,CD,00,FF in 6 consecutive cycles.
  - `in_ready` pulses only on the `out_last` cycles.
- **Backpressure:** word 16'hBEEF with `out_ready`=0 for 3 cycles after `out_valid` rises, then 1.
  - BE is held stable for 4 cycles, then EF follows.
  - `in_ready`=0 throughout the stall.
- **Reset mid-word:** accept 16'hC0DE, transfer C0, assert `rst` for 1 cycle.
  - DE is never emitted.
  - All outputs are 0 and `in_ready`=1 the next cycle.
- **LSB-first, wide:** WORD_W=32, MSB_FIRST=0, word 32'h11223344.
  - Bytes 44,33,22,11.
  - `out_last` only on 11.
- **Producer held off:** `in_valid` asserted with a second word during the first byte of a 32-bit word.
  - The second word is not accepted until the cycle of the final byte's transfer.
  - The second word's first byte immediately follows.
